// File: rtl/stone_drawer_pkg.sv
// Shared definitions for the stone RAM: field positions, type codes,
// colours and screen geometry. The rope controller imports the same
// field positions so both sides agree on the entry layout.
package stone_pkg;

  // Sprite and screen geometry
  localparam int SPRITE_SIZE = 16;
  localparam int SCREEN_W    = 320;
  localparam int SCREEN_H    = 240;

  // Cycles from draw_index valid to ram_q valid
  localparam int RAM_LATENCY = 2;

  // RAM entry field bit positions
  localparam int X_MSB    = 31;
  localparam int X_LSB    = 23;
  localparam int Y_MSB    = 18;
  localparam int Y_LSB    = 11;
  localparam int TYPE_MSB = 3;
  localparam int TYPE_LSB = 2;
  localparam int VIS      = 1;
  localparam int MOV      = 0;

  // Stone type codes
  typedef enum logic [1:0] {
    TYPE_STONE       = 2'd0,
    TYPE_GOLD        = 2'd1,
    TYPE_DIAMOND     = 2'd2,
    TYPE_DIAMOND_ALT = 2'd3
  } stone_type_e;

  // Sprite colours (3-bit RGB)
  localparam logic [2:0] COLOUR_STONE   = 3'b111;
  localparam logic [2:0] COLOUR_GOLD    = 3'b110;
  localparam logic [2:0] COLOUR_DIAMOND = 3'b011;

  // Drawer sequencing states
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_WAIT,
    ST_LATCH,
    ST_DRAW,
    ST_NEXT,
    ST_FIN
  } draw_state_e;

  // Fields of one entry that rendering depends on
  typedef struct packed {
    logic [8:0]  x;
    logic [7:0]  y;
    stone_type_e kind;
    logic        visible;
  } stone_entry_t;

  // Pull the rendering fields out of a raw RAM word
  function automatic stone_entry_t unpack_entry(input logic [31:0] word);
    stone_entry_t e;
    e.x       = word[X_MSB:X_LSB];
    e.y       = word[Y_MSB:Y_LSB];
    e.kind    = stone_type_e'(word[TYPE_MSB:TYPE_LSB]);
    e.visible = word[VIS];
    return e;
  endfunction

endpackage

// File: rtl/stone_drawer_if.sv
// Bundle between the stone drawer and its surroundings: pass control,
// the shared RAM read port and the pixel plot stream to the VGA adapter.
interface stone_drawer_if;

  logic        start;
  logic [3:0]  quantity;
  logic [31:0] ram_q;
  logic        draw_stone_flag;
  logic [3:0]  draw_index;
  logic        plot;
  logic [8:0]  plot_x;
  logic [7:0]  plot_y;
  logic [2:0]  plot_colour;
  logic        busy;
  logic        done;

  // Controller / RAM side
  modport master (
    output start, quantity, ram_q,
    input  draw_stone_flag, draw_index, plot, plot_x, plot_y,
           plot_colour, busy, done
  );

  // Drawer side
  modport slave (
    input  start, quantity, ram_q,
    output draw_stone_flag, draw_index, plot, plot_x, plot_y,
           plot_colour, busy, done
  );

endinterface

// File: rtl/stone_drawer_palette.sv
// Combinational sprite lookup: colour from stone type, and transparency
// for the four corner pixels of the 16x16 sprite.
module stone_palette
  import stone_pkg::*;
(
  input  stone_type_e type_i,
  input  logic [3:0]  col_i,
  input  logic [3:0]  row_i,
  output logic [2:0]  colour_o,
  output logic        opaque_o
);

  localparam logic [3:0] EDGE_LAST = 4'(SPRITE_SIZE - 1);

  logic col_edge;
  logic row_edge;

  // Colour by type; both diamond codes share a colour
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned and infers a latch.
    colour_o = COLOUR_DIAMOND;
    case (type_i)
      TYPE_STONE: colour_o = COLOUR_STONE;
      TYPE_GOLD:  colour_o = COLOUR_GOLD;
      default:    colour_o = COLOUR_DIAMOND;
    endcase
  end

  // Corners are where both column and row sit on a sprite edge
  always_comb begin
    col_edge = (col_i == 4'd0) || (col_i == EDGE_LAST);
    row_edge = (row_i == 4'd0) || (row_i == EDGE_LAST);
    opaque_o = !(col_edge && row_edge);
  end

endmodule

// File: rtl/stone_drawer.sv
// Read side of the shared stone RAM. Each accepted start walks entries
// 0..quantity-1, latches every entry once, and for visible stones emits
// a clipped 16x16 sprite as single-pixel plot strobes. All outputs are
// registered from next-state values so they line up with the state they
// describe.
module stone_drawer
  import stone_pkg::*;
(
  input  logic          clock,
  input  logic          reset,
  stone_drawer_if.slave bus
);

  localparam logic [3:0] WAIT_LAST = 4'(RAM_LATENCY - 2);
  localparam logic [7:0] K_LAST    = 8'(SPRITE_SIZE * SPRITE_SIZE - 1);

  // Sequencer state and counters
  draw_state_e  state_q, state_d;
  logic [3:0]   index_q, index_d;
  logic [3:0]   qty_q,   qty_d;
  logic [7:0]   k_q,     k_d;
  logic [3:0]   wait_q,  wait_d;
  stone_entry_t entry_q, entry_d;

  // Registered outputs
  logic         flag_q,   flag_d;
  logic [3:0]   dindex_q, dindex_d;
  logic         plot_q,   plot_d;
  logic [8:0]   plot_x_q, plot_x_d;
  logic [7:0]   plot_y_q, plot_y_d;
  logic [2:0]   colour_q, colour_d;
  logic         busy_q,   busy_d;
  logic         done_q,   done_d;

  // Pixel geometry for the upcoming cycle
  logic [3:0]   col;
  logic [3:0]   row;
  logic [9:0]   px;
  logic [8:0]   py;
  logic [2:0]   pal_colour;
  logic         pal_opaque;
  logic         in_draw;

  // RAM bits that do not affect rendering (spare bits and the moving flag)
  logic         unused_ram_bits;
  assign unused_ram_bits = ^{bus.ram_q[22:19], bus.ram_q[10:4], bus.ram_q[MOV]};

  // Next-state sequencing: start, RAM wait, latch, sprite scan, advance
  always_comb begin
    state_d = state_q;
    index_d = index_q;
    qty_d   = qty_q;
    k_d     = k_q;
    wait_d  = wait_q;
    entry_d = entry_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          qty_d   = bus.quantity;
          index_d = '0;
          state_d = (bus.quantity == 4'd0) ? ST_FIN : ST_ADDR;
        end
      end
      ST_ADDR: begin
        wait_d  = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (wait_q == WAIT_LAST) state_d = ST_LATCH;
        else                     wait_d  = wait_q + 4'd1;
      end
      ST_LATCH: begin
        // Entry is captured once here; rope writes during DRAW cannot tear it
        entry_d = unpack_entry(bus.ram_q);
        k_d     = '0;
        state_d = entry_d.visible ? ST_DRAW : ST_NEXT;
      end
      ST_DRAW: begin
        if (k_q == K_LAST) state_d = ST_NEXT;
        else               k_d     = k_q + 8'd1;
      end
      ST_NEXT: begin
        if (index_q + 4'd1 == qty_q) begin
          state_d = ST_FIN;
        end else begin
          index_d = index_q + 4'd1;
          state_d = ST_ADDR;
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Sprite colour and corner mask for the pixel about to be presented
  stone_palette u_palette (
    .type_i   (entry_d.kind),
    .col_i    (col),
    .row_i    (row),
    .colour_o (pal_colour),
    .opaque_o (pal_opaque)
  );

  // Output values for the upcoming cycle, including screen clipping
  always_comb begin
    col     = k_d[3:0];
    row     = k_d[7:4];
    // Widened by one bit so sprites hanging off the right/bottom edge
    // compare correctly against the screen limits instead of wrapping
    px      = {1'b0, entry_d.x} + {6'd0, col};
    py      = {1'b0, entry_d.y} + {5'd0, row};
    in_draw = (state_d == ST_DRAW);

    plot_d   = in_draw && pal_opaque
               && (px < 10'(SCREEN_W)) && (py < 9'(SCREEN_H));
    plot_x_d = in_draw ? px[8:0] : '0;
    plot_y_d = in_draw ? py[7:0] : '0;
    colour_d = in_draw ? pal_colour : '0;
    flag_d   = (state_d != ST_IDLE);
    busy_d   = (state_d != ST_IDLE);
    done_d   = (state_d == ST_FIN);
    dindex_d = (state_d != ST_IDLE) ? index_d : '0;
  end

  // Sequencer registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      index_q <= '0;
      qty_q   <= '0;
      k_q     <= '0;
      wait_q  <= '0;
      entry_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values regardless of statement order.
      state_q <= state_d;
      index_q <= index_d;
      qty_q   <= qty_d;
      k_q     <= k_d;
      wait_q  <= wait_d;
      entry_q <= entry_d;
    end
  end

  // Output registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      flag_q   <= 1'b0;
      dindex_q <= '0;
      plot_q   <= 1'b0;
      plot_x_q <= '0;
      plot_y_q <= '0;
      colour_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      flag_q   <= flag_d;
      dindex_q <= dindex_d;
      plot_q   <= plot_d;
      plot_x_q <= plot_x_d;
      plot_y_q <= plot_y_d;
      colour_q <= colour_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.draw_stone_flag = flag_q;
  assign bus.draw_index      = dindex_q;
  assign bus.plot            = plot_q;
  assign bus.plot_x          = plot_x_q;
  assign bus.plot_y          = plot_y_q;
  assign bus.plot_colour     = colour_q;
  assign bus.busy            = busy_q;
  assign bus.done            = done_q;

endmodule

// File: tb/tb_stone_drawer.sv
// Scoreboard bench for stone_drawer: stimulus loads the RAM model, starts
// passes and queues the expected plot strobes and done pulses; a monitor
// on the falling edge pops and compares whenever the DUT presents them.
module tb_stone_drawer;
  import stone_pkg::*;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  stone_drawer_if bus ();

  stone_drawer dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // RAM model with two cycles of read latency
  logic [31:0] ram [16];
  logic [31:0] ram_pipe;
  always @(posedge clock) begin
    ram_pipe   <= ram[bus.draw_index];
    bus.ram_q  <= ram_pipe;
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [8:0] x;
    logic [7:0] y;
    logic [2:0] c;
  } plot_exp_t;

  plot_exp_t exp_q[$];
  int        done_q[$];
  int        plot_cyc_log[$];
  int        plot_total    = 0;
  int        done_total    = 0;
  int        last_done_cyc = -1;
  int        checks        = 0;
  int        failures      = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] mk(input int x, input int y, input int ty,
                                     input bit vis, input bit mov);
    logic [31:0] w;
    w = '0;
    w[31:23] = 9'(x);
    w[18:11] = 8'(y);
    w[3:2]   = 2'(ty);
    w[1]     = vis;
    w[0]     = mov;
    return w;
  endfunction

  // Reference timing: ADDR at cur, DRAW at cur+3..cur+258, FIN after the last entry
  task automatic expect_pass(input int t0, input int qty);
    int cur;
    cur = t0 + 1;
    for (int e = 0; e < qty; e++) begin
      logic [31:0] w;
      logic [2:0]  c;
      w = ram[e];
      c = (w[3:2] == 2'd0) ? 3'b111 : (w[3:2] == 2'd1) ? 3'b110 : 3'b011;
      if (w[1]) begin
        for (int k = 0; k < 256; k++) begin
          int col, row, px, py;
          plot_exp_t pe;
          col = k % 16;
          row = k / 16;
          px  = int'(w[31:23]) + col;
          py  = int'(w[18:11]) + row;
          if (!((col == 0 || col == 15) && (row == 0 || row == 15))
              && px < 320 && py < 240) begin
            pe.cyc = cur + 3 + k;
            pe.x   = px[8:0];
            pe.y   = py[7:0];
            pe.c   = c;
            exp_q.push_back(pe);
          end
        end
        cur += 260;
      end else begin
        cur += 4;
      end
    end
    done_q.push_back(cur);
  endtask

  // Monitor: compares every plot strobe and done pulse against the queues
  always @(negedge clock) begin
    if (reset === 1'b0) begin
      if (bus.plot === 1'b1) begin
        plot_total++;
        plot_cyc_log.push_back(cyc);
        if (exp_q.size() == 0) begin
          check("plot_unexpected", 32'(bus.plot), 32'd0);
        end else begin
          plot_exp_t pe;
          pe = exp_q.pop_front();
          check("plot_cycle",  32'(cyc),             32'(pe.cyc));
          check("plot_x",      32'(bus.plot_x),      32'(pe.x));
          check("plot_y",      32'(bus.plot_y),      32'(pe.y));
          check("plot_colour", 32'(bus.plot_colour), 32'(pe.c));
        end
      end
      if (bus.done === 1'b1) begin
        done_total++;
        last_done_cyc = cyc;
        if (done_q.size() == 0) begin
          check("done_unexpected", 32'(bus.done), 32'd0);
        end else begin
          check("done_cycle", 32'(cyc), 32'(done_q.pop_front()));
        end
        check("done_flag", 32'(bus.draw_stone_flag), 32'd1);
        check("done_busy", 32'(bus.busy), 32'd1);
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_plot"},   32'(bus.plot),            32'd0);
    check({tag, "_x"},      32'(bus.plot_x),          32'd0);
    check({tag, "_y"},      32'(bus.plot_y),          32'd0);
    check({tag, "_colour"}, 32'(bus.plot_colour),     32'd0);
    check({tag, "_index"},  32'(bus.draw_index),      32'd0);
    check({tag, "_flag"},   32'(bus.draw_stone_flag), 32'd0);
    check({tag, "_busy"},   32'(bus.busy),            32'd0);
    check({tag, "_done"},   32'(bus.done),            32'd0);
  endtask

  // One full pass with hand-computed plot count, first-plot and done cycles
  task automatic run_pass(input string tag, input int qty, input int n_plots,
                          input int first_rel, input int done_rel, input int poke_rel);
    int t0, p0, waited;
    p0 = plot_total;
    @(posedge clock); #1;
    bus.quantity = 4'(qty);
    bus.start    = 1'b1;
    t0           = cyc;
    expect_pass(t0, qty);
    @(posedge clock); #1;
    bus.start = 1'b0;
    @(negedge clock);
    check({tag, "_c1_flag"}, 32'(bus.draw_stone_flag), 32'd1);
    check({tag, "_c1_busy"}, 32'(bus.busy), 32'd1);
    if (qty > 0) check({tag, "_c1_index"}, 32'(bus.draw_index), 32'd0);
    else         check({tag, "_c1_done"},  32'(bus.done), 32'd1);
    if (poke_rel > 0) begin
      while (cyc < t0 + poke_rel) begin
        @(posedge clock); #1;
      end
      bus.start = 1'b1;
      @(posedge clock); #1;
      bus.start = 1'b0;
    end
    waited = 0;
    @(negedge clock);
    while (bus.busy === 1'b1 && waited < 2000) begin
      @(negedge clock);
      waited++;
    end
    check({tag, "_finished"},  32'(bus.busy), 32'd0);
    check({tag, "_done_rel"},  32'(last_done_cyc - t0), 32'(done_rel));
    check({tag, "_idle_rel"},  32'(cyc - t0), 32'(done_rel + 1));
    check({tag, "_flag_idle"}, 32'(bus.draw_stone_flag), 32'd0);
    check({tag, "_plots"},     32'(plot_total - p0), 32'(n_plots));
    if (n_plots > 0) check({tag, "_first_rel"}, 32'(plot_cyc_log[p0] - t0), 32'(first_rel));
    check({tag, "_exp_left"},  32'(exp_q.size()), 32'd0);
    check({tag, "_done_left"}, 32'(done_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0;
    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.quantity = '0;
    for (int i = 0; i < 16; i++) ram[i] = '0;
    repeat (3) @(posedge clock);
    #1;
    check_all_zero("reset");
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(posedge clock);

    // Gold stone fully on screen
    ram[0] = mk(100, 50, 1, 1'b1, 1'b0);
    run_pass("gold", 1, 252, 5, 261, 0);

    // Invisible entry skipped, stone at origin
    ram[0] = mk(5, 5, 0, 1'b0, 1'b0);
    ram[1] = mk(0, 0, 0, 1'b1, 1'b0);
    run_pass("skip", 2, 252, 9, 265, 0);

    // Moving diamond clipped at bottom-right corner of the screen
    ram[0] = mk(310, 230, 2, 1'b1, 1'b1);
    run_pass("clip", 1, 99, 5, 261, 0);

    // Empty pass goes straight to FIN
    run_pass("empty", 0, 0, 0, 1, 0);

    // Start pulsed mid-pass is ignored
    ram[0] = mk(100, 50, 1, 1'b1, 1'b0);
    run_pass("poke", 1, 252, 5, 261, 100);

    // Asynchronous reset mid-DRAW, then a clean restart
    @(posedge clock); #1;
    bus.quantity = 4'd1;
    bus.start    = 1'b1;
    t0           = cyc;
    expect_pass(t0, 1);
    @(posedge clock); #1;
    bus.start = 1'b0;
    while (cyc < t0 + 50) begin
      @(posedge clock); #1;
    end
    check("mid_draw_busy", 32'(bus.busy), 32'd1);
    #1;
    reset = 1'b1;
    #1;
    check_all_zero("async_reset");
    exp_q.delete();
    done_q.delete();
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    run_pass("restart", 1, 252, 5, 261, 0);

    repeat (5) @(posedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
